// File: rtl/imem_loader.sv
// Boot-time loader: turns a length-prefixed little-endian byte stream into instruction-memory writes,
// holding the core in reset until done. Define IMEM_LOADER_CHKSUM_EN to require a trailing XOR checksum byte.
module imem_loader #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [7:0]            s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  core_rstn,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [2:0] {LEN0, LEN1, DATA, CHK, RUN, ERR} state_e;

  state_e                state_q, state_d;
  logic [15:0]           len_q, len_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [ADDR_WIDTH:0]   word_idx_q, word_idx_d;
  logic [23:0]           part_q, part_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
`ifdef IMEM_LOADER_CHKSUM_EN
  logic [7:0]            chk_q, chk_d;
`endif

  logic        accept;
  logic [15:0] len_n;
  logic        len_too_big;
  logic        last_word;
  logic        word_done;
  logic        release_now;
  logic        fault_now;

  assign accept      = s_valid & s_ready;
  assign len_n       = {s_data, len_q[7:0]};
  assign len_too_big = 32'(len_n) > (32'd1 << ADDR_WIDTH);
  // Index is one bit wider than the address so a completely full memory never wraps back to 0.
  assign last_word   = (32'(word_idx_q) + 32'd1) == 32'(len_q);
  assign word_done   = accept && (state_q == DATA) && (byte_cnt_q == 2'd3);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= LEN0;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LEN0: if (accept) state_d = LEN1;
      LEN1: begin
        if (accept) begin
          if (len_too_big) begin
            state_d = ERR;
          end else if (len_n == 16'd0) begin
`ifdef IMEM_LOADER_CHKSUM_EN
            state_d = CHK;
`else
            state_d = RUN;
`endif
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (word_done && last_word) begin
`ifdef IMEM_LOADER_CHKSUM_EN
          state_d = CHK;
`else
          state_d = RUN;
`endif
        end
      end
      CHK: begin
`ifdef IMEM_LOADER_CHKSUM_EN
        if (accept) state_d = (s_data == chk_q) ? RUN : ERR;
`else
        state_d = ERR;
`endif
      end
      RUN:     state_d = RUN;
      ERR:     state_d = ERR;
      default: state_d = ERR;
    endcase
  end

  // Release is registered on entering RUN from the header/checksum, but only once RUN is visible
  // after the payload, so the last write strobe completes before the core leaves reset.
  always_comb begin
    s_ready     = (state_q == LEN0) || (state_q == LEN1) || (state_q == DATA) || (state_q == CHK);
    release_now = (state_q == RUN);
    fault_now   = accept && (state_q == LEN1) && len_too_big;
`ifdef IMEM_LOADER_CHKSUM_EN
    if (accept && (state_q == CHK)) begin
      release_now = (s_data == chk_q);
      fault_now   = (s_data != chk_q);
    end
`else
    if (accept && (state_q == LEN1) && (len_n == 16'd0)) release_now = 1'b1;
`endif
  end

  always_comb begin
    len_d       = len_q;
    byte_cnt_d  = byte_cnt_q;
    word_idx_d  = word_idx_q;
    part_d      = part_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
`ifdef IMEM_LOADER_CHKSUM_EN
    chk_d       = chk_q;
`endif
    if (accept) begin
      case (state_q)
        LEN0: len_d[7:0]  = s_data;
        LEN1: len_d[15:8] = s_data;
        DATA: begin
          byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef IMEM_LOADER_CHKSUM_EN
          chk_d = chk_q ^ s_data;
`endif
          case (byte_cnt_q)
            2'd0: part_d[7:0]   = s_data;
            2'd1: part_d[15:8]  = s_data;
            2'd2: part_d[23:16] = s_data;
            default: begin
              mem_we_d    = 1'b1;
              mem_addr_d  = word_idx_q[ADDR_WIDTH-1:0];
              mem_wdata_d = {s_data, part_q};
              word_idx_d  = word_idx_q + (ADDR_WIDTH+1)'(1);
            end
          endcase
        end
        default: ;
      endcase
    end
    done_d  = done_q | release_now;
    error_d = error_q | fault_now;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      len_q       <= '0;
      byte_cnt_q  <= '0;
      word_idx_q  <= '0;
      part_q      <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
`ifdef IMEM_LOADER_CHKSUM_EN
      chk_q       <= '0;
`endif
    end else begin
      len_q       <= len_d;
      byte_cnt_q  <= byte_cnt_d;
      word_idx_q  <= word_idx_d;
      part_q      <= part_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      done_q      <= done_d;
      error_q     <= error_d;
`ifdef IMEM_LOADER_CHKSUM_EN
      chk_q       <= chk_d;
`endif
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign done      = done_q;
  assign core_rstn = done_q;
  assign error     = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader (ADDR_WIDTH=4); follows IMEM_LOADER_CHKSUM_EN when defined.
module tb_imem_loader;
  localparam int AW = 4;

  logic          clk;
  logic          rstn;
  logic [7:0]    s_data;
  logic          s_valid;
  logic          s_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          core_rstn;
  logic          done;
  logic          error;

  int   total = 0;
  int   bad = 0;
  int   writeCount = 0;
  int   backToBack = 0;
  int   wc0 = 0;
  logic weLast = 1'b0;

  imem_loader #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rstn(rstn), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .core_rstn(core_rstn), .done(done), .error(error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (mem_we) writeCount++;
    if (mem_we && weLast) backToBack++;
    weLast = mem_we;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    s_data  = b;
    s_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycle();
    s_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset(input string tag);
    rstn    = 1'b0;
    s_valid = 1'b0;
    #3;
    checkOutput({tag, "_sready"}, 32'(s_ready), 32'd1);
    checkOutput({tag, "_we"}, 32'(mem_we), 32'd0);
    checkOutput({tag, "_addr"}, 32'(mem_addr), 32'd0);
    checkOutput({tag, "_wdata"}, mem_wdata, 32'd0);
    checkOutput({tag, "_corerstn"}, 32'(core_rstn), 32'd0);
    checkOutput({tag, "_done"}, 32'(done), 32'd0);
    checkOutput({tag, "_error"}, 32'(error), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic sendWord(input logic [31:0] w, input logic [AW-1:0] addr, input bit gap, input string tag);
    for (int j = 0; j < 4; j++) begin
      applyStimulus(w[8*j +: 8]);
      if (j == 3) begin
        checkOutput({tag, "_we"}, 32'(mem_we), 32'd1);
        checkOutput({tag, "_addr"}, 32'(mem_addr), 32'(addr));
        checkOutput({tag, "_wdata"}, mem_wdata, w);
      end else begin
        checkOutput({tag, "_we_idle"}, 32'(mem_we), 32'd0);
      end
      if (gap) begin
        idleCycle();
        checkOutput({tag, "_we_gap"}, 32'(mem_we), 32'd0);
      end
    end
  endtask

  task automatic runN2(input bit gap, input string tag);
    applyStimulus(8'h02);
    if (gap) idleCycle();
    applyStimulus(8'h00);
    if (gap) idleCycle();
    sendWord(32'h00100513, 4'd0, gap, {tag, "_w0"});
    sendWord(32'h00200593, 4'd1, gap, {tag, "_w1"});
  endtask

  initial begin
    logic [31:0] w;
    rstn    = 1'b1;
    s_valid = 1'b0;
    s_data  = 8'h00;
    #1;
    doReset("rst0");

    // Full-rate two-word image
    wc0 = writeCount;
    runN2(1'b0, "full");
`ifdef IMEM_LOADER_CHKSUM_EN
    checkOutput("full_sready_chk", 32'(s_ready), 32'd1);
    checkOutput("full_done_early", 32'(done), 32'd0);
    applyStimulus(8'hB0);
    checkOutput("full_we_after", 32'(mem_we), 32'd0);
`else
    checkOutput("full_done_early", 32'(done), 32'd0);
    checkOutput("full_corerstn_early", 32'(core_rstn), 32'd0);
    checkOutput("full_sready_run", 32'(s_ready), 32'd0);
    idleCycle();
    checkOutput("full_we_after", 32'(mem_we), 32'd0);
`endif
    checkOutput("full_done", 32'(done), 32'd1);
    checkOutput("full_corerstn", 32'(core_rstn), 32'd1);
    checkOutput("full_sready_after", 32'(s_ready), 32'd0);
    applyStimulus(8'hFF);
    applyStimulus(8'h13);
    idleCycle();
    checkOutput("full_done_hold", 32'(done), 32'd1);
    checkOutput("full_error", 32'(error), 32'd0);
    checkOutput("full_writes", 32'(writeCount - wc0), 32'd2);

    // Same image with s_valid toggling
    doReset("rst1");
    wc0 = writeCount;
    runN2(1'b1, "gap");
`ifdef IMEM_LOADER_CHKSUM_EN
    checkOutput("gap_done_early", 32'(done), 32'd0);
    applyStimulus(8'hB0);
    idleCycle();
`endif
    checkOutput("gap_done", 32'(done), 32'd1);
    checkOutput("gap_corerstn", 32'(core_rstn), 32'd1);
    checkOutput("gap_sready", 32'(s_ready), 32'd0);
    checkOutput("gap_writes", 32'(writeCount - wc0), 32'd2);

    // Empty image
    doReset("rst2");
    wc0 = writeCount;
    applyStimulus(8'h00);
    applyStimulus(8'h00);
`ifdef IMEM_LOADER_CHKSUM_EN
    checkOutput("zero_done_early", 32'(done), 32'd0);
    checkOutput("zero_sready_chk", 32'(s_ready), 32'd1);
    applyStimulus(8'h00);
`endif
    checkOutput("zero_done", 32'(done), 32'd1);
    checkOutput("zero_corerstn", 32'(core_rstn), 32'd1);
    checkOutput("zero_sready", 32'(s_ready), 32'd0);
    idleCycle();
    checkOutput("zero_writes", 32'(writeCount - wc0), 32'd0);

    // Oversized image (17 words into a 16-word memory)
    doReset("rst3");
    wc0 = writeCount;
    applyStimulus(8'h11);
    applyStimulus(8'h00);
    checkOutput("big_error", 32'(error), 32'd1);
    checkOutput("big_corerstn", 32'(core_rstn), 32'd0);
    checkOutput("big_sready", 32'(s_ready), 32'd0);
    applyStimulus(8'h13);
    idleCycle();
    checkOutput("big_done", 32'(done), 32'd0);
    checkOutput("big_writes", 32'(writeCount - wc0), 32'd0);

    // Exactly full memory: word k holds bytes 4k..4k+3
    doReset("rst4");
    wc0 = writeCount;
    applyStimulus(8'h10);
    applyStimulus(8'h00);
    for (int k = 0; k < 16; k++) begin
      w = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
      sendWord(w, 4'(k), 1'b0, "fill");
    end
`ifdef IMEM_LOADER_CHKSUM_EN
    applyStimulus(8'h00);
`else
    checkOutput("fill_done_early", 32'(done), 32'd0);
    idleCycle();
`endif
    checkOutput("fill_done", 32'(done), 32'd1);
    checkOutput("fill_error", 32'(error), 32'd0);
    checkOutput("fill_writes", 32'(writeCount - wc0), 32'd16);

    // Reset mid-load, then reload from address 0
    doReset("rst5");
    applyStimulus(8'h02);
    applyStimulus(8'h00);
    sendWord(32'h00100513, 4'd0, 1'b0, "mid_w0");
    applyStimulus(8'h93);
    applyStimulus(8'h05);
    doReset("rstmid");
    runN2(1'b0, "reload");
`ifdef IMEM_LOADER_CHKSUM_EN
    applyStimulus(8'hB0);
`else
    idleCycle();
`endif
    checkOutput("reload_done", 32'(done), 32'd1);

`ifdef IMEM_LOADER_CHKSUM_EN
    // Bad checksum keeps the core in reset
    doReset("rst6");
    runN2(1'b0, "badchk");
    applyStimulus(8'hB1);
    checkOutput("badchk_error", 32'(error), 32'd1);
    checkOutput("badchk_corerstn", 32'(core_rstn), 32'd0);
    checkOutput("badchk_done", 32'(done), 32'd0);
    idleCycle();
    checkOutput("badchk_corerstn_hold", 32'(core_rstn), 32'd0);
`endif

    checkOutput("no_back_to_back", 32'(backToBack), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
